// File: rtl/iter_compare_unit.sv
// Multi-cycle signed/unsigned magnitude comparator, scanning CHUNK bits per cycle MSB-first.
// Optional early exit on first differing chunk: define ITER_COMPARE_EARLY_EXIT_EN.
module iter_compare_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // RUN   | comparing one chunk per cycle, MSB chunk first
  // DONE  | result presented, held until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_sl, b_sl;
  logic             sl_diff;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
    assign a_chunk[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
    assign b_chunk[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
  end

  assign a_sl    = a_chunk[cnt_q];
  assign b_sl    = b_chunk[cnt_q];
  assign sl_diff = (a_sl != b_sl);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    lt_d      = lt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d            = a;
          b_d            = b;
          a_d[WIDTH-1]   = a[WIDTH-1] ^ is_signed;
          b_d[WIDTH-1]   = b[WIDTH-1] ^ is_signed;
          cnt_d          = '0;
          decided_d      = 1'b0;
          lt_d           = 1'b0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (!decided_q && sl_diff) begin
          decided_d = 1'b1;
          lt_d      = (a_sl < b_sl);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
`ifdef ITER_COMPARE_EARLY_EXIT_EN
        if (!decided_q && sl_diff) state_d = DONE;
`else
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      lt_q      <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign lt        = out_valid & lt_q;
  assign eq        = out_valid & ~decided_q;

endmodule

// File: tb/tb_iter_compare_unit.sv
// Self-checking bench for iter_compare_unit (WIDTH=64, CHUNK=8): vector table plus scoreboard.
module tb_iter_compare_unit;
  localparam int WIDTH  = 64;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int TMO    = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             lt;
  logic             eq;
  logic             busy;

  iter_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .lt(lt), .eq(eq), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             lt;
    logic             eq;
  } vec_t;

  typedef struct {
    logic lt;
    logic eq;
    int   lat;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected latency from the first differing chunk (MSB chunk is index 0).
  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int k;
    k = NCHUNK;
    for (int i = NCHUNK - 1; i >= 0; i--)
      if (x[WIDTH-1-i*CHUNK -: CHUNK] != y[WIDTH-1-i*CHUNK -: CHUNK]) k = i;
`ifdef ITER_COMPARE_EARLY_EXIT_EN
    return (k < NCHUNK) ? k + 1 : NCHUNK;
`else
    return NCHUNK;
`endif
  endfunction

  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vs, input logic elt, input logic eeq);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    a = va; b = vb; is_signed = vs; in_valid = 1'b1;
    @(posedge clk);
    e.lt = elt; e.eq = eeq; e.lat = exp_lat(va, vb);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a = '1; b = '0; is_signed = ~vs;
  endtask

  // Waits for out_valid, counting edges since accept, then pops the scoreboard.
  task automatic collect(input string name);
    exp_t e;
    int   n;
    logic idle_bad;
    n = 0;
    idle_bad = 1'b0;
    while (!out_valid && n < TMO) begin
      if (lt || eq) idle_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    check({name, "_quiet"}, idle_bad, 1'b0);
    if (!out_valid) begin
      check({name, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check({name, "_unexpected"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_lat"}, n, e.lat);
      check({name, "_lt"}, lt, e.lt);
      check({name, "_eq"}, eq, e.eq);
    end
  endtask

  initial begin
    logic hold_lt, hold_eq;
    vecs[0] = '{64'd1, 64'd2, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{64'h0100_0000_0000_0000, 64'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{64'd5, 64'd3, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{64'h0000_1234_0000_0000, 64'h0000_1234_0000_0001, 1'b0, 1'b1, 1'b0};

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lt_eq", {lt, eq}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lt, vecs[i].eq);
      collect($sformatf("vec%0d", i));
      @(posedge clk); #1;
      check($sformatf("vec%0d_release", i), {out_valid, in_ready, lt, eq}, 4'b0100);
    end

    // Backpressure: result held, new offer ignored until after handshake.
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0009, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0);
    collect("bp");
    hold_lt = lt; hold_eq = eq;
    a = 64'd0; b = 64'd1; is_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), {out_valid, lt, eq, in_ready, busy},
            {1'b1, hold_lt, hold_eq, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    begin
      exp_t e;
      e.lt = 1'b1; e.eq = 1'b0; e.lat = exp_lat(64'd0, 64'd1);
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    check("bp_new_accepted", busy, 1'b1);
    collect("bp_new");
    @(posedge clk); #1;

    // Reset in the 3rd RUN cycle abandons the operation.
    send(64'd7, 64'd8, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {out_valid, lt, eq, busy, in_ready}, 5'b00001);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {out_valid, in_ready}, 2'b01);
    send(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    collect("post_rst");
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
